// File: rtl/shift_entry_reg.sv
// Symbol-wide entry shift register: fill, rotate and arithmetic shifts in either
// direction, parallel load, synchronous clear, entered-symbol count with full/overflow.
module shift_entry_reg #(
  parameter  int WIDTH = 8,
  parameter  int SYM_W = 1,
  localparam int DEPTH = WIDTH / SYM_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic [SYM_W-1:0] d,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [SYM_W-1:0] sout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             ovf
);

  // Strobe semantics: en is a single-cycle request with no ready/back-pressure;
  // every cycle en is high (and clr/load are low) performs exactly one shift, and
  // the result is visible on the outputs the cycle after the sampling edge.

  localparam logic [1:0] MODE_FILL  = 2'd0;
  localparam logic [1:0] MODE_ROT   = 2'd1;
  localparam logic [1:0] MODE_ARITH = 2'd2;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SYM_W-1:0] sout_q, sout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [SYM_W-1:0] outgoing;
  logic [SYM_W-1:0] ins;
  logic [WIDTH-1:0] ins_lo;
  logic [WIDTH-1:0] ins_hi;
  logic             full_w;

  assign full_w = (count_q == CNT_W'(DEPTH));

  always_comb begin
    out_d   = out_q;
    sout_d  = sout_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    outgoing = dir ? out_q[SYM_W-1:0] : out_q[WIDTH-1 -: SYM_W];
    case (mode)
      MODE_FILL:  ins = d;
      MODE_ROT:   ins = outgoing;
      MODE_ARITH: ins = dir ? {SYM_W{out_q[WIDTH-1]}} : '0;
      default:    ins = '0;
    endcase
    // Shift operators keep SYM_W == WIDTH legal (no zero-width slices).
    ins_lo = WIDTH'(ins);
    ins_hi = ins_lo << (WIDTH - SYM_W);

    if (clr) begin
      out_d   = '0;
      sout_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      out_d   = load_data;
      count_d = CNT_W'(DEPTH);
      ovf_d   = 1'b0;
    end else if (en && mode != 2'd3) begin
      out_d  = dir ? ((out_q >> SYM_W) | ins_hi) : ((out_q << SYM_W) | ins_lo);
      sout_d = outgoing;
      if (mode == MODE_FILL) begin
        if (full_w) ovf_d = 1'b1;
        else        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q   <= '0;
      sout_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      sout_q  <= sout_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out   = out_q;
  assign sout  = sout_q;
  assign count = count_q;
  assign full  = full_w;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_shift_entry_reg.sv
// Bench for shift_entry_reg: binary (8x1) and hex (16x4) instances driven from one
// stimulus stream, checked against an arithmetic reference model via expected queues.
module tb_shift_entry_reg;

  localparam int EW = 50;  // {out[31:0], sout[7:0], count[7:0], full, ovf}

  logic clk;
  logic rstn;

  logic       clr_a, load_a, en_a, dir_a;
  logic [7:0] ld_a;
  logic [0:0] d_a;
  logic [1:0] mode_a;
  logic [7:0] out_a;
  logic [0:0] sout_a;
  logic [3:0] count_a;
  logic       full_a, ovf_a;

  logic        clr_b, load_b, en_b, dir_b;
  logic [15:0] ld_b;
  logic [3:0]  d_b;
  logic [1:0]  mode_b;
  logic [15:0] out_b;
  logic [3:0]  sout_b;
  logic [2:0]  count_b;
  logic        full_b, ovf_b;

  shift_entry_reg #(.WIDTH(8), .SYM_W(1)) dut_a (
    .clk(clk), .rstn(rstn), .clr(clr_a), .load(load_a), .load_data(ld_a),
    .en(en_a), .d(d_a), .dir(dir_a), .mode(mode_a),
    .out(out_a), .sout(sout_a), .count(count_a), .full(full_a), .ovf(ovf_a)
  );

  shift_entry_reg #(.WIDTH(16), .SYM_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .clr(clr_b), .load(load_b), .load_data(ld_b),
    .en(en_b), .d(d_b), .dir(dir_b), .mode(mode_b),
    .out(out_b), .sout(sout_b), .count(count_b), .full(full_b), .ovf(ovf_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          mw[2] = '{8, 16};
  int          ms[2] = '{1, 4};
  logic [63:0] m_val[2];
  int          m_sout[2];
  int          m_cnt[2];
  bit          m_ovf[2];

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];

  int checks   = 0;
  int failures = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_sout[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit c, input bit l, input logic [63:0] ld,
                            input bit e, input int dv, input bit dr, input int md);
    logic [63:0] mask, smask, og, ins;
    int depth;
    mask  = (64'd1 << mw[i]) - 1;
    smask = (64'd1 << ms[i]) - 1;
    depth = mw[i] / ms[i];
    if (c) begin
      m_val[i] = 0; m_sout[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
    end else if (l) begin
      m_val[i] = ld & mask; m_cnt[i] = depth; m_ovf[i] = 0;
    end else if (e && md != 3) begin
      og = dr ? (m_val[i] & smask) : ((m_val[i] >> (mw[i] - ms[i])) & smask);
      if (md == 0)      ins = 64'(dv) & smask;
      else if (md == 1) ins = og;
      else              ins = (dr && ((m_val[i] >> (mw[i] - 1)) & 1) != 0) ? smask : 0;
      if (dr) m_val[i] = (m_val[i] >> ms[i]) | (ins << (mw[i] - ms[i]));
      else    m_val[i] = ((m_val[i] << ms[i]) | ins) & mask;
      m_sout[i] = int'(og);
      if (md == 0) begin
        if (m_cnt[i] == depth) m_ovf[i] = 1;
        else                   m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [EW-1:0] model_pack(input int i);
    logic [7:0] s8, c8;
    s8 = 8'(m_sout[i]);
    c8 = 8'(m_cnt[i]);
    return {m_val[i][31:0], s8, c8, (m_cnt[i] == mw[i] / ms[i]), m_ovf[i]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int sel, input bit c, input bit l, input logic [31:0] ld,
                       input bit e, input int dv, input bit dr, input int md);
    @(negedge clk);
    clr_a = 0; load_a = 0; en_a = 0; dir_a = 1'($urandom); mode_a = 2'($urandom);
    clr_b = 0; load_b = 0; en_b = 0; dir_b = 1'($urandom); mode_b = 2'($urandom);
    d_a = 1'($urandom); d_b = 4'($urandom); ld_a = 8'($urandom); ld_b = 16'($urandom);
    if (sel == 0) begin
      clr_a = c; load_a = l; ld_a = ld[7:0]; en_a = e; d_a = 1'(dv); dir_a = dr; mode_a = 2'(md);
      model_step(0, c, l, 64'(ld[7:0]), e, dv, dr, md);
    end else begin
      clr_b = c; load_b = l; ld_b = ld[15:0]; en_b = e; d_b = 4'(dv); dir_b = dr; mode_b = 2'(md);
      model_step(1, c, l, 64'(ld[15:0]), e, dv, dr, md);
    end
    exp_q_a.push_back(model_pack(0));
    exp_q_b.push_back(model_pack(1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e, g;
    #1;
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      g = {32'(out_a), 8'(sout_a), 8'(count_a), full_a, ovf_a};
      chk("sb_a", 64'(g), 64'(e));
    end
  end

  always @(posedge clk) begin
    logic [EW-1:0] e, g;
    #1;
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      g = {32'(out_b), 8'(sout_b), 8'(count_b), full_b, ovf_b};
      chk("sb_b", 64'(g), 64'(e));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    clr_a = 0; load_a = 0; en_a = 0; d_a = 0; dir_a = 0; mode_a = 0; ld_a = 0;
    clr_b = 0; load_b = 0; en_b = 0; d_b = 0; dir_b = 0; mode_b = 0; ld_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_a", 64'(out_a), 0);
    chk("reset_cnt_a", 64'(count_a), 0);
    chk("reset_out_b", 64'(out_b), 0);
    chk("reset_full_b", 64'(full_b), 0);
    @(negedge clk);
    rstn = 1'b1;

    // binary fill, both directions
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    settle();
    chk("fill3_out", 64'(out_a), 64'h05);
    chk("fill3_cnt", 64'(count_a), 3);
    chk("fill3_full", 64'(full_a), 0);
    chk("fill3_sout", 64'(sout_a), 0);
    drive(0, 0, 0, 0, 1, 1, 1, 0);
    settle();
    chk("fillr_out", 64'(out_a), 64'h82);
    chk("fillr_sout", 64'(sout_a), 1);

    // hex entry up to full, then overflow
    for (int k = 1; k <= 4; k++) drive(1, 0, 0, 0, 1, k, 0, 0);
    settle();
    chk("hex4_out", 64'(out_b), 64'h1234);
    chk("hex4_full", 64'(full_b), 1);
    chk("hex4_ovf", 64'(ovf_b), 0);
    drive(1, 0, 0, 0, 1, 5, 0, 0);
    settle();
    chk("hex5_out", 64'(out_b), 64'h2345);
    chk("hex5_sout", 64'(sout_b), 1);
    chk("hex5_cnt", 64'(count_b), 4);
    chk("hex5_ovf", 64'(ovf_b), 1);

    // rotate
    drive(0, 0, 1, 32'h81, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 1);
    settle();
    chk("rotr_out", 64'(out_a), 64'hC0);
    chk("rotr_cnt", 64'(count_a), 8);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    settle();
    chk("rotl2_out", 64'(out_a), 64'h03);
    chk("rotl2_sout", 64'(sout_a), 1);

    // arithmetic
    drive(0, 0, 1, 32'h80, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 2);
    settle();
    chk("asr_neg", 64'(out_a), 64'hC0);
    drive(0, 0, 1, 32'h40, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 2);
    settle();
    chk("asr_pos", 64'(out_a), 64'h20);
    drive(0, 0, 1, 32'h81, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 2);
    settle();
    chk("asl_out", 64'(out_a), 64'h02);
    chk("asl_sout", 64'(sout_a), 1);

    // priority
    drive(0, 1, 1, 32'hFF, 1, 1, 0, 0);
    settle();
    chk("prio_clr_out", 64'(out_a), 0);
    chk("prio_clr_cnt", 64'(count_a), 0);
    drive(0, 0, 1, 32'h3C, 1, 1, 0, 0);
    settle();
    chk("prio_ld_out", 64'(out_a), 64'h3C);
    chk("prio_ld_cnt", 64'(count_a), 8);

    // asynchronous reset mid-operation with en held high
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 1, 0, 0);
    settle();
    chk("pre_rst_out", 64'(out_a), 64'h07);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_out", 64'(out_a), 0);
    chk("arst_cnt", 64'(count_a), 0);
    chk("arst_sout", 64'(sout_a), 0);
    chk("arst_ovf", 64'(ovf_a), 0);
    @(negedge clk);
    en_a = 1'b0;
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 3);
    settle();
    chk("hold_out", 64'(out_a), 0);

    // randomized traffic on both instances
    for (int k = 0; k < 800; k++) begin
      drive(int'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 12) == 0), $urandom, ($urandom_range(0, 9) < 7),
            int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_a_drained", 64'(exp_q_a.size()), 0);
    chk("queue_b_drained", 64'(exp_q_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_entry_reg.md
Name: shift_entry_reg

Overview:
Parametrised successor to the single-bit shift register used for push-button data entry. It shifts SYM_W-bit symbols (1 = binary entry, 4 = hex-digit entry) into a WIDTH-bit register, in either direction. It supports fill, rotate and arithmetic modes, a parallel load and a synchronous clear. It tracks how many symbols have been entered, with full and sticky overflow flags, and drives the seven-segment decoders and downstream ALU operand registers.

Parameters:
WIDTH, 8, register width in bits; must be a multiple of SYM_W.
SYM_W, 1, bits per shift operation (symbol width); 1..WIDTH.
(derived) DEPTH = WIDTH/SYM_W symbols; CNT_W = $clog2(DEPTH+1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rstn  input  1  reset, asynchronous, active-low.
clr  input  1  synchronous clear, one-cycle pulse.
load  input  1  synchronous parallel load, one-cycle pulse.
load_data  input  WIDTH  value written on load.
en  input  1  shift strobe, one-cycle pulse (driven by edge-detected buttons).
d  input  SYM_W  symbol shifted in (fill mode only).
dir  input  1  0 = left (new symbol enters at LSB end), 1 = right (enters at MSB end).
mode  input  2  0 fill, 1 rotate, 2 arithmetic, 3 hold.
out  output  WIDTH  current register contents.
sout  output  SYM_W  symbol shifted out by the most recent shift (registered).
count  output  CNT_W  symbols entered since last clr/load/reset, saturating at DEPTH.
full  output  1  count == DEPTH (combinational from count).
ovf  output  1  sticky: a fill shift occurred while full.

Behaviour:
- Async reset (rstn low): out=0, sout=0, count=0, ovf=0, full=0. Holds while rstn low; release is synchronised by the external synchroniser.
- Priority per cycle: clr > load > en. Lower-priority inputs are ignored in a cycle where a higher one is asserted.
- clr: out=0, sout=0, count=0, ovf=0.
- load: out=load_data, count=DEPTH, ovf=0, sout unchanged.
- en, mode 0 fill:
  - dir=0: out={out[WIDTH-SYM_W-1:0],d}, sout=out[WIDTH-1 -: SYM_W].
  - dir=1: out={d,out[WIDTH-1:SYM_W]}, sout=out[SYM_W-1:0].
  - count increments and saturates at DEPTH.
  - If count==DEPTH before the shift, ovf is set (sticky).
- en, mode 1 rotate: same as fill with d replaced by the outgoing symbol (no data lost). sout=outgoing symbol. count and ovf unchanged.
- en, mode 2 arithmetic:
  - dir=0: fills SYM_W zeros at the LSB end.
  - dir=1: fills SYM_W copies of out[WIDTH-1] at the MSB end.
  - sout=outgoing symbol; count and ovf unchanged.
- en, mode 3 hold: no state change, including sout.
- No en/clr/load: all state held.
- Latency: out/sout/count/ovf are valid the cycle after the strobe edge. One shift per en-high cycle; en held high shifts every cycle.
- SYM_W==WIDTH: each shift replaces the whole register. DEPTH=1; rotate leaves out unchanged.
- Edge cases: out is never X after reset. count never exceeds DEPTH. mode/dir may change every cycle with no side effects when en is low.

Test Plan:
- Default params, fill, dir=0: en with d=1,0,1 -> out=8'h05, count=3, full=0, sout=0. Then dir=1, d=1 -> out=8'h82, sout=1.
- WIDTH=16, SYM_W=4, fill, dir=0: digits 1,2,3,4 -> out=16'h1234, count=4, full=1, ovf=0. Digit 5 -> out=16'h2345, sout=4'h1, count=4, ovf=1.
- Default params: load 8'h81, rotate, dir=1 -> out=8'hC0, sout=1, count=8. Rotate dir=0 twice -> out=8'h03 (first step 8'h81, sout=1), then 8'h03 (sout=1).
- Default params, arithmetic: load 8'h80, dir=1 -> 8'hC0. Load 8'h40, dir=1 -> 8'h20. Load 8'h81, dir=0 -> 8'h02, sout=1.
- Priority: clr=load=en=1 with load_data=8'hFF -> out=0, count=0, ovf=0. load=en=1, load_data=8'h3C, d=1, fill -> out=8'h3C, count=8.
- Reset mid-operation: after three fill shifts (out=8'h07) and with en held high, assert rstn low between edges -> out, count, sout, ovf go 0 immediately. After release with en=0, state holds at 0. Mode 3 with en=1 -> no change.
